// File: rtl/gps_bridge_pkg.sv
// Shared types and constants for the GPS sample packer and SPI bridge.
package gps_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StNib0 = 2'd1,
        StNib1 = 2'd2
    } gps_pack_state_e;

    // Bit positions of each front-end line inside a packed nibble.
    localparam int unsigned NIB_I1 = 3;
    localparam int unsigned NIB_I0 = 2;
    localparam int unsigned NIB_Q1 = 1;
    localparam int unsigned NIB_Q0 = 0;

    localparam int unsigned GPS_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/gps_byte_fifo.sv
// Synchronous show-ahead FIFO with full/empty/level; a push while full is only
// accepted when a pop frees a slot in the same cycle.
module gps_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Gate the head with empty so the output reads zero after reset/flush.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gps_sample_packer.sv
// Synchronizes GPS front-end I/Q samples, packs two nibbles per byte and buffers them.
// Optional GPS_PACKER_OVF_CNT_EN adds the saturating OVF_COUNT output.
module gps_sample_packer
    import gps_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = GPS_FIFO_DEPTH_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        MCU_CLK_25_000,
    input  logic                        RST,
    input  logic                        GPS_CLK,
    input  logic                        GPS_I1,
    input  logic                        GPS_I0,
    input  logic                        GPS_Q1,
    input  logic                        GPS_Q0,
    input  logic                        ENABLE,
    output logic [7:0]                  BYTE_DATA,
    output logic                        BYTE_VALID,
    input  logic                        BYTE_READY,
    output logic                        OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
`ifdef GPS_PACKER_OVF_CNT_EN
    ,
    output logic [7:0]                  OVF_COUNT
`endif
);

    localparam int unsigned CLK_BIT = 4;
    localparam int unsigned LAST    = SYNC_STAGES - 1;

    // Clock and data share one chain so every bit sees identical latency.
    logic [4:0]      pin_vec;
    logic [4:0]      sync_q [SYNC_STAGES];
    logic            gclk_prev_q;
    logic            gclk_edge;
    logic [3:0]      nibble;

    gps_pack_state_e state_q, state_d;
    logic [3:0]      hold_q, hold_d;
    logic            push;
    logic            enable_q;
    logic            enable_rise;
    logic            overflow_q;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;

    always_comb begin
        pin_vec         = '0;
        pin_vec[CLK_BIT] = GPS_CLK;
        pin_vec[NIB_I1] = GPS_I1;
        pin_vec[NIB_I0] = GPS_I0;
        pin_vec[NIB_Q1] = GPS_Q1;
        pin_vec[NIB_Q0] = GPS_Q0;
    end

    always_ff @(posedge MCU_CLK_25_000) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            gclk_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= pin_vec;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            gclk_prev_q <= sync_q[LAST][CLK_BIT];
        end
    end

    assign gclk_edge = sync_q[LAST][CLK_BIT] & ~gclk_prev_q;
    assign nibble    = sync_q[LAST][3:0];

    always_ff @(posedge MCU_CLK_25_000) begin
        if (RST) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            enable_q <= ENABLE;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                if (ENABLE) begin
                    state_d = StNib0;
                end
            end
            StNib0: begin
                if (!ENABLE) begin
                    state_d = StIdle;
                end else if (gclk_edge) begin
                    hold_d  = nibble;
                    state_d = StNib1;
                end
            end
            StNib1: begin
                if (!ENABLE) begin
                    state_d = StIdle;
                end else if (gclk_edge) begin
                    push    = 1'b1;
                    state_d = StNib0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    gps_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (MCU_CLK_25_000),
        .rst       (RST),
        .push      (push),
        .push_data ({hold_q, nibble}),
        .pop       (BYTE_READY),
        .rd_data   (BYTE_DATA),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (FIFO_LEVEL)
    );

    assign BYTE_VALID  = ~fifo_empty;
    // A full FIFO still takes the byte when the consumer pops in the same cycle.
    assign drop        = push & fifo_full & ~BYTE_READY;
    assign enable_rise = ENABLE & ~enable_q;

    always_ff @(posedge MCU_CLK_25_000) begin
        if (RST || enable_rise) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign OVERFLOW = overflow_q;

`ifdef GPS_PACKER_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge MCU_CLK_25_000) begin
        if (RST || enable_rise) begin
            ovf_cnt_q <= '0;
        end else if (drop && ovf_cnt_q != 8'hFF) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign OVF_COUNT = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_gps_sample_packer.sv
// Directed bench for gps_sample_packer: vector table plus multi-cycle corner sequences.
module tb_gps_sample_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       gps_clk;
    logic       gps_i1, gps_i0, gps_q1, gps_q0;
    logic       enable;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       overflow;
    logic [4:0] fifo_level;
`ifdef GPS_PACKER_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif

    int checks   = 0;
    int failures = 0;

    gps_sample_packer #(
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .MCU_CLK_25_000 (clk),
        .RST            (rst),
        .GPS_CLK        (gps_clk),
        .GPS_I1         (gps_i1),
        .GPS_I0         (gps_i0),
        .GPS_Q1         (gps_q1),
        .GPS_Q0         (gps_q0),
        .ENABLE         (enable),
        .BYTE_DATA      (byte_data),
        .BYTE_VALID     (byte_valid),
        .BYTE_READY     (byte_ready),
        .OVERFLOW       (overflow),
        .FIFO_LEVEL     (fifo_level)
`ifdef GPS_PACKER_OVF_CNT_EN
        ,
        .OVF_COUNT      (ovf_count)
`endif
    );

    always #20 clk = ~clk;

    // Monitor: record every accepted byte and count valid cycles.
    logic [7:0] got [$];
    int         valid_cycles = 0;

    always @(negedge clk) begin
        if (byte_valid === 1'b1) valid_cycles++;
        if (byte_valid === 1'b1 && byte_ready === 1'b1) got.push_back(byte_data);
    end

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] got_at(input int idx);
        logic [7:0] unknown;
        unknown = 8'hxx;
        if (idx >= 0 && idx < got.size()) return got[idx];
        return unknown;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_nib(input logic [3:0] nib);
        {gps_i1, gps_i0, gps_q1, gps_q0} = nib;
    endtask

    // One sample, GPS_CLK aligned to the MCU clock: 3 cycles low, 3 high (~4 MHz).
    task automatic sample(input logic [3:0] nib);
        gps_clk = 1'b0;
        set_nib(nib);
        wait_cycles(3);
        gps_clk = 1'b1;
        wait_cycles(3);
    endtask

    task automatic reenable();
        enable = 1'b0;
        wait_cycles(2);
        enable = 1'b1;
        wait_cycles(2);
    endtask

    task automatic fill16();
        for (int n = 0; n < 16; n++) begin
            sample(4'(n));
            sample(4'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bad;
        int first_bad;
        logic [7:0] exp_q [$];
        logic [3:0] h, l;

        vecs[0] = '{hi: 4'hA, lo: 4'h5, exp_byte: 8'hA5};
        vecs[1] = '{hi: 4'h0, lo: 4'h0, exp_byte: 8'h00};
        vecs[2] = '{hi: 4'hF, lo: 4'hF, exp_byte: 8'hFF};
        vecs[3] = '{hi: 4'h3, lo: 4'hC, exp_byte: 8'h3C};
        vecs[4] = '{hi: 4'h8, lo: 4'h1, exp_byte: 8'h81};
        vecs[5] = '{hi: 4'h1, lo: 4'h8, exp_byte: 8'h18};

        rst = 1'b1; enable = 1'b0; byte_ready = 1'b0; gps_clk = 1'b0;
        set_nib(4'h0);
        wait_cycles(3);
        check("reset_data", 32'(byte_data), 32'h00);
        check("reset_valid", 32'(byte_valid), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);
        check("reset_level", 32'(fifo_level), 32'h0);
        rst = 1'b0;
        wait_cycles(1);
        enable = 1'b1;
        byte_ready = 1'b1;
        wait_cycles(2);

        // Packing table; vector 0 is the basic 0xA5 case.
        for (int v = 0; v < 6; v++) begin
            base = got.size();
            bad  = valid_cycles;
            sample(vecs[v].hi);
            sample(vecs[v].lo);
            wait_cycles(4);
            check($sformatf("pack_count[%0d]", v), 32'(got.size() - base), 32'd1);
            check($sformatf("pack_byte[%0d]", v), 32'(got_at(base)), 32'(vecs[v].exp_byte));
            if (v == 0) begin
                check("basic_valid_cycles", 32'(valid_cycles - bad), 32'd1);
                check("basic_overflow", 32'(overflow), 32'h0);
            end
        end

        // Backpressure: 16 bytes fill, the 17th is dropped.
        byte_ready = 1'b0;
        fill16();
        check("bp_level_full", 32'(fifo_level), 32'd16);
        check("bp_overflow_before", 32'(overflow), 32'h0);
        sample(4'h1);
        sample(4'h1);
        check("bp_overflow_after", 32'(overflow), 32'h1);
        check("bp_level_after_drop", 32'(fifo_level), 32'd16);
        check("bp_head_stable", 32'(byte_data), 32'h00);
`ifdef GPS_PACKER_OVF_CNT_EN
        check("bp_ovf_count", 32'(ovf_count), 32'd1);
`endif
        base = got.size();
        byte_ready = 1'b1;
        wait_cycles(20);
        check("bp_drain_count", 32'(got.size() - base), 32'd16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (got_at(base + i) !== 8'(i << 4)) bad++;
        end
        check("bp_drain_order_errors", 32'(bad), 32'd0);
        check("bp_level_empty", 32'(fifo_level), 32'd0);

        // Push of 0x3C lands in the same cycle as a single pop while full.
        reenable();
        check("ena_rise_clears_ovf", 32'(overflow), 32'h0);
        byte_ready = 1'b0;
        fill16();
        sample(4'h3);
        gps_clk = 1'b0;
        set_nib(4'hC);
        wait_cycles(3);
        gps_clk = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 byte_ready = 1'b1;
        @(posedge clk);
        #2 byte_ready = 1'b0;
        check("simul_level", 32'(fifo_level), 32'd16);
        check("simul_overflow", 32'(overflow), 32'h0);
        wait_cycles(3);
        base = got.size();
        byte_ready = 1'b1;
        wait_cycles(20);
        check("simul_drain_count", 32'(got.size() - base), 32'd16);
        check("simul_first", 32'(got_at(base)), 32'h10);
        check("simul_last", 32'(got_at(base + 15)), 32'h3C);

        // Partial byte is discarded when ENABLE drops.
        base = got.size();
        sample(4'h7);
        reenable();
        sample(4'h1);
        sample(4'h2);
        wait_cycles(4);
        check("abort_count", 32'(got.size() - base), 32'd1);
        check("abort_byte", 32'(got_at(base)), 32'h12);

        // Reset with 5 bytes queued and OVERFLOW set.
        byte_ready = 1'b0;
        fill16();
        sample(4'h9);
        sample(4'h9);
        byte_ready = 1'b1;
        wait_cycles(11);
        byte_ready = 1'b0;
        check("rst_pre_level", 32'(fifo_level), 32'd5);
        check("rst_pre_overflow", 32'(overflow), 32'h1);
        gps_clk = 1'b0;
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        check("rst_valid", 32'(byte_valid), 32'h0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_data", 32'(byte_data), 32'h00);
`ifdef GPS_PACKER_OVF_CNT_EN
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
`endif

        // 8 MHz asynchronous stream of random nibbles, 1000 bytes.
        byte_ready = 1'b1;
        wait_cycles(4);
        base = got.size();
        @(posedge clk);
        #1;
        for (int b = 0; b < 1000; b++) begin
            h = 4'($urandom_range(15));
            l = 4'($urandom_range(15));
            exp_q.push_back({h, l});
            gps_clk = 1'b0; set_nib(h); #63; gps_clk = 1'b1; #62;
            gps_clk = 1'b0; set_nib(l); #63; gps_clk = 1'b1; #62;
        end
        gps_clk = 1'b0;
        wait_cycles(30);
        check("rand_count", 32'(got.size() - base), 32'd1000);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 1000; i++) begin
            if (got_at(base + i) !== exp_q[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        if (bad != 0) $display("first stream difference at byte %0d", first_bad);
        check("rand_stream_errors", 32'(bad), 32'd0);
        check("rand_overflow", 32'(overflow), 32'h0);
`ifdef GPS_PACKER_OVF_CNT_EN
        check("rand_ovf_count", 32'(ovf_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gps_sample_packer.md
Name: gps_sample_packer

Overview:
- Upstream neighbour of the SPI bridge state machine.
- Captures 2-bit I and 2-bit Q GPS front-end samples on synchronized GPS_CLK rising edges and packs two samples per byte.
- Buffers packed bytes in a small FIFO and presents them on a valid/ready byte interface that the SPI serializer drains.
- Runs entirely in the MCU_CLK_25_000 domain; GPS_CLK is treated as data.

Parameters:
- FIFO_DEPTH, 16, byte entries in the FIFO; power of two, 4..64.
- SYNC_STAGES, 2, synchronizer flops on GPS_CLK and on the four data bits; same depth for all five so they stay aligned.

Ports:
- MCU_CLK_25_000  input  1  system clock, 25.000 MHz.
- RST  input  1  synchronous, active-high reset.
- GPS_CLK  input  1  front-end sample clock, asynchronous; must be ≤ 8 MHz (front-end runs at 4.092 MHz).
- GPS_I1, GPS_I0, GPS_Q1, GPS_Q0  input  1 each  front-end sign/magnitude bits, asynchronous.
- ENABLE  input  1  capture enable.
- BYTE_DATA  output  8  head-of-FIFO byte.
- BYTE_VALID  output  1  BYTE_DATA is valid.
- BYTE_READY  input  1  consumer accepts the byte this cycle.
- OVERFLOW  output  1  sticky flag: a packed byte was dropped.
- FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset values: BYTE_DATA=0, BYTE_VALID=0, OVERFLOW=0, FIFO_LEVEL=0; FSM=IDLE; synchronizers=0.
- Synchronization and edge detect:
  - GPS_CLK and the data bits each pass through SYNC_STAGES flops.
  - One extra flop on synced GPS_CLK gives edge = sync & ~prev.
  - On an edge cycle, the nibble {I1,I0,Q1,Q0} is taken from the synced data registers.
  - Latency: pin edge to capture is SYNC_STAGES+1 clocks.
- FSM states: IDLE, NIB0, NIB1.
  - IDLE: while ENABLE=0, stay. When ENABLE=1, go to NIB0 next cycle. Edges in IDLE are ignored.
  - NIB0: on edge, hold[7:4]=nibble and go to NIB1.
  - NIB1: on edge, push {hold[7:4], nibble} into the FIFO and go to NIB0.
  - ENABLE=0 in NIB0 or NIB1: go to IDLE and discard the partial nibble. FIFO contents are kept and stay drainable.
- FIFO (show-ahead):
  - A byte pushed in cycle n drives BYTE_VALID=1 and BYTE_DATA in cycle n+1 if the FIFO was empty.
  - Pop occurs when BYTE_VALID & BYTE_READY.
  - BYTE_DATA stays stable while BYTE_VALID=1 and BYTE_READY=0.
- Boundary conditions:
  - Full, push, no pop: byte dropped, OVERFLOW set, FIFO unchanged.
  - Full, push, pop same cycle: push accepted, level unchanged.
  - Empty, push and BYTE_READY=1 same cycle: no pop that cycle, since BYTE_VALID was 0.
  - Pointers wrap modulo FIFO_DEPTH. FIFO_LEVEL saturates at FIFO_DEPTH (full) and 0 (empty).
- OVERFLOW is cleared only by RST or by a 0→1 transition of ENABLE.
- RST mid-operation: FIFO is flushed, the partial byte is lost, and all outputs return to reset values on the next cycle.

Optional Feature:
- Macro: GPS_PACKER_OVF_CNT_EN.
- Defined:
  - Adds output OVF_COUNT[7:0]: a saturating count of dropped bytes, holding at 255.
  - Cleared together with OVERFLOW (RST or ENABLE rising edge).
- Undefined: the port is absent and only the sticky OVERFLOW flag exists.

Decomposition:
- Shared package gps_bridge_pkg holds:
  - FSM state typedef (IDLE/NIB0/NIB1).
  - Nibble bit-order constants (I1=3, I0=2, Q1=1, Q0=0).
  - Default FIFO depth.
- One sub-module: gps_byte_fifo, a synchronous show-ahead FIFO with full/empty/level outputs. Reusable by the SPI bridge.
- The synchronizer and FSM stay inline.

Test Plan:
- Basic packing: RST then ENABLE=1; drive GPS_CLK at 4 MHz with nibbles 0xA then 0x5; BYTE_READY=1. Expect exactly one byte 0xA5, BYTE_VALID high for one cycle, OVERFLOW=0.
- Backpressure: BYTE_READY=0; push 16 bytes 0x00..0xF0 (nibble pairs n,0). Expect FIFO_LEVEL=16. The 17th byte is dropped and OVERFLOW=1. Release BYTE_READY: bytes drain in order 0x00..0xF0 and FIFO_LEVEL returns to 0.
- Simultaneous push/pop at full: FIFO full, BYTE_READY pulses in the same cycle as a push of 0x3C. Expect FIFO_LEVEL stays 16, OVERFLOW stays 0, and 0x3C is drained last.
- Partial byte abort: capture one nibble 0x7, drop ENABLE, re-enable, then feed 0x1, 0x2. Expect a single output byte 0x12 (no 0x7x).
- Reset mid-stream: FIFO holding 5 bytes with OVERFLOW=1; assert RST for one cycle. Next cycle expect BYTE_VALID=0, FIFO_LEVEL=0, OVERFLOW=0, BYTE_DATA=0.
- GPS_CLK glitch-free timing: GPS_CLK at 8 MHz with random nibbles, 1000 bytes, BYTE_READY=1. Expect output exactly matches the packed reference model with no drops. With GPS_PACKER_OVF_CNT_EN defined, OVF_COUNT=0.
